// File: rtl/spi_regfile_peripheral.sv
// spi_regfile_peripheral: SPI mode-0 write/readback access to NUM_REGS x DATA_W registers.
// Define SPI_READBACK_EN to compile in the cipo read path.
module spi_regfile_peripheral #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_strobe,
    output logic [6:0]                 wr_addr,
    output logic [7:0]                 err_count
);
    localparam int L = 8 + DATA_W;
    typedef enum logic [1:0] {IDLE, CMD, DATA, COMMIT} state_t;
    state_t state_q, state_d;
    logic [2:0] sclk_q;
    logic [1:0] copi_q, ncs_q;
    logic ncs_prev_q;
    logic [5:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic rw_q, rw_d;
    logic [6:0] addr_q, addr_d, wr_addr_q, wr_addr_d, addr_new;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic wr_strobe_q, wr_strobe_d;
    logic [7:0] err_q, err_d;
    logic sclk_rise, ncs_fall, ncs_rise, sel, cmd_done, len_ok, addr_ok, wr_ok, rd_err;
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign ncs_fall = ~ncs_q[1] & ncs_prev_q;
    assign ncs_rise = ncs_q[1] & ~ncs_prev_q;
    assign sel = ~ncs_q[1];
    assign addr_new = {sr_q[5:0], copi_q[1]};
    assign cmd_done = state_q == CMD && sel && sclk_rise && cnt_q == 6'd7;
    assign len_ok = cnt_q == 6'(L);
    assign addr_ok = int'(addr_q) < NUM_REGS;
    assign wr_ok = rw_q && len_ok && addr_ok;
`ifdef SPI_READBACK_EN
    assign rd_err = !rw_q && !len_ok;
`else
    assign rd_err = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        sr_d = sr_q;
        rw_d = rw_q;
        addr_d = addr_q;
        regs_d = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d = wr_addr_q;
        err_d = err_q;
        case (state_q)
            IDLE: if (ncs_fall) begin
                state_d = CMD;
                cnt_d = '0;
                sr_d = '0;
                rw_d = 1'b0;
                addr_d = '0;
            end
            CMD, DATA: begin
                if (sel && sclk_rise) begin
                    cnt_d = cnt_q == 6'd63 ? cnt_q : cnt_q + 6'd1;
                    sr_d = {sr_q[DATA_W-2:0], copi_q[1]};
                end
                if (cmd_done) begin
                    rw_d = sr_q[6];
                    addr_d = addr_new;
                    state_d = DATA;
                end
                if (ncs_rise) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                if (wr_ok) begin
                    regs_d[int'(addr_q)*DATA_W +: DATA_W] = sr_q;
                    wr_addr_d = addr_q;
                    wr_strobe_d = 1'b1;
                end
                if ((rw_q && !wr_ok) || rd_err) err_d = err_q == 8'hFF ? err_q : err_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            copi_q <= '0;
            ncs_q <= '1;
            ncs_prev_q <= 1'b1;
            state_q <= IDLE;
            cnt_q <= '0;
            sr_q <= '0;
            rw_q <= 1'b0;
            addr_q <= '0;
            regs_q <= {NUM_REGS{RESET_VAL}};
            wr_strobe_q <= 1'b0;
            wr_addr_q <= '0;
            err_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            copi_q <= {copi_q[0], copi};
            ncs_q <= {ncs_q[0], ncs};
            ncs_prev_q <= ncs_q[1];
            state_q <= state_d;
            cnt_q <= cnt_d;
            sr_q <= sr_d;
            rw_q <= rw_d;
            addr_q <= addr_d;
            regs_q <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q <= wr_addr_d;
            err_q <= err_d;
        end
    end
    assign regs = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr = wr_addr_q;
    assign err_count = err_q;
`ifdef SPI_READBACK_EN
    logic sclk_fall, cipo_q;
    logic [DATA_W-1:0] shadow_q;
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    // Shadow loads on the 8th rise so the MSB is on cipo before the 9th rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            cipo_q <= 1'b0;
        end else if (cmd_done) begin
            shadow_q <= int'(addr_new) < NUM_REGS ? regs_q[int'(addr_new)*DATA_W +: DATA_W] : '0;
        end else if (state_q == DATA && sel && sclk_fall) begin
            cipo_q <= shadow_q[DATA_W-1];
            shadow_q <= {shadow_q[DATA_W-2:0], 1'b0};
        end
    end
    assign cipo = cipo_q;
    assign cipo_oe = sel;
`else
    assign cipo = 1'b0;
    assign cipo_oe = 1'b0;
`endif
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// tb_spi_regfile_peripheral: directed SPI frames with a write-commit scoreboard.
// Readback expectations follow SPI_READBACK_EN.
module tb_spi_regfile_peripheral;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, copi = 1'b0, ncs = 1'b1, ncs2 = 1'b1;
    logic cipo, cipo_oe, wr_strobe, cipo2, cipo_oe2, wr_strobe2;
    logic [63:0] regs, regs2;
    logic [6:0] wr_addr, wr_addr2;
    logic [7:0] err_count, err_count2;
    int checks = 0, failures = 0;
    logic [63:0] model = '0, model2 = '0;
    int exp_err = 0;
    logic [39:0] rd_bits = '0;
    logic oe_mid = 1'b0, strobe_prev = 1'b0;
    typedef struct {bit inst2; logic [6:0] addr; logic [15:0] data;} exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    spi_regfile_peripheral dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs(regs), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .err_count(err_count)
    );
    spi_regfile_peripheral #(.NUM_REGS(4), .DATA_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs2),
        .cipo(cipo2), .cipo_oe(cipo_oe2), .regs(regs2), .wr_strobe(wr_strobe2),
        .wr_addr(wr_addr2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic frame(input logic [39:0] bits, input int n, input bit to2);
        if (to2) ncs2 = 1'b0;
        else ncs = 1'b0;
        #60;
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            #60;
            rd_bits = {rd_bits[38:0], cipo};
            oe_mid = cipo_oe;
            sclk = 1'b1;
            #60;
            sclk = 1'b0;
        end
        #60;
        ncs = 1'b1;
        ncs2 = 1'b1;
        #100;
    endtask

    task automatic wr1(input logic [6:0] a, input logic [7:0] d);
        exp_q.push_back('{1'b0, a, {8'h00, d}});
        model[int'(a)*8 +: 8] = d;
        frame(40'({1'b1, a, d}), 16, 1'b0);
    endtask

    task automatic wr2(input logic [6:0] a, input logic [15:0] d);
        exp_q.push_back('{1'b1, a, d});
        model2[int'(a)*16 +: 16] = d;
        frame(40'({1'b1, a, d}), 24, 1'b1);
    endtask

    always @(negedge clk) begin
        if (wr_strobe || wr_strobe2) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe got=%0b/%0b exp=none", wr_strobe, wr_strobe2);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_inst2", 64'(wr_strobe2), 64'(mon_e.inst2));
                if (mon_e.inst2) begin
                    chk("wr_addr2", 64'(wr_addr2), 64'(mon_e.addr));
                    chk("reg2_data", 64'(regs2[int'(mon_e.addr)*16 +: 16]), 64'(mon_e.data));
                end else begin
                    chk("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
                    chk("reg_data", 64'(regs[int'(mon_e.addr)*8 +: 8]), 64'(mon_e.data[7:0]));
                end
            end
        end
        if (wr_strobe && strobe_prev) begin
            checks++;
            failures++;
            $display("FAIL strobe_double got=1 exp=0");
        end
        strobe_prev = wr_strobe;
    end

    initial begin
        #100 rst_n = 1'b1;
        #50;
        chk("rst_regs", regs, 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_oe", 64'(cipo_oe), 64'd0);
        chk("rst_strobe", 64'(wr_strobe), 64'd0);
        chk("rst_regs2", regs2, 64'd0);
        wr1(7'd3, 8'hA5);
        chk("wr3_regs", regs, model);
        chk("wr3_err", 64'(err_count), 64'd0);
        wr1(7'd0, 8'h5A);
        wr1(7'd7, 8'hFF);
        chk("wr07_regs", regs, model);
        frame(40'({1'b1, 7'd1, 7'h55}), 15, 1'b0);
        frame(40'({1'b1, 7'd1, 9'h1AA}), 17, 1'b0);
        exp_err = 2;
        chk("len_err", 64'(err_count), 64'(exp_err));
        chk("len_regs", regs, model);
        frame(40'({1'b1, 7'd8, 8'h11}), 16, 1'b0);
        chk("addr8_err", 64'(err_count), 64'(++exp_err));
        frame(40'({1'b1, 7'd127, 8'h22}), 16, 1'b0);
        chk("addr127_err", 64'(err_count), 64'(++exp_err));
        chk("addr_regs", regs, model);
        frame(40'({1'b0, 7'd3, 8'h00}), 16, 1'b0);
        chk("rd3_data", 64'(rd_bits[7:0]), RB ? 64'hA5 : 64'h0);
        chk("rd3_oe", 64'(oe_mid), 64'(RB));
        chk("rd3_err", 64'(err_count), 64'(exp_err));
        frame(40'({1'b0, 7'd3, 2'b00}), 10, 1'b0);
        exp_err += int'(RB);
        chk("rd_short_err", 64'(err_count), 64'(exp_err));
        wr1(7'd5, 8'h3C);
        frame(40'({1'b0, 7'd5, 8'h00}), 16, 1'b0);
        chk("rd5_data", 64'(rd_bits[7:0]), RB ? 64'h3C : 64'h0);
        frame(40'({1'b0, 7'd9, 8'h00}), 16, 1'b0);
        chk("rd9_data", 64'(rd_bits[7:0]), 64'h0);
        chk("rd_regs", regs, model);
        ncs = 1'b0;
        #60;
        for (int i = 15; i >= 6; i--) begin
            copi = i == 15 || i == 9;
            #60 sclk = 1'b1;
            #60 sclk = 1'b0;
        end
        rst_n = 1'b0;
        #20;
        ncs = 1'b1;
        #50;
        model = '0;
        model2 = '0;
        exp_err = 0;
        chk("mid_rst_regs", regs, model);
        chk("mid_rst_err", 64'(err_count), 64'd0);
        chk("mid_rst_oe", 64'(cipo_oe), 64'd0);
        chk("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
        rst_n = 1'b1;
        #100;
        wr1(7'd6, 8'h77);
        chk("post_rst_regs", regs, model);
        chk("post_rst_err", 64'(err_count), 64'd0);
        for (int k = 0; k < 255; k++) frame(40'({1'b1, 7'd2, 1'b1}), 9, 1'b0);
        chk("sat_255", 64'(err_count), 64'd255);
        frame(40'({1'b1, 7'd2, 1'b1}), 9, 1'b0);
        chk("sat_hold", 64'(err_count), 64'd255);
        chk("sat_regs", regs, model);
        wr2(7'd2, 16'hBEEF);
        chk("w16_regs2", regs2, model2);
        frame(40'({1'b1, 7'd2, 8'h12}), 16, 1'b1);
        chk("w16_len_err", 64'(err_count2), 64'd1);
        chk("w16_len_regs2", regs2, model2);
        chk("w16_no_cross", regs, model);
        #100;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_regfile_peripheral.md
# spi_regfile_peripheral

SPI mode-0 peripheral giving an external SPI controller write (and optional read) access to a parametrised bank of configuration registers. Generalises the two-register, 8-bit SPI-to-PWM peripheral to `NUM_REGS` registers of `DATA_W` bits each. Adds strict frame-length checking, an error counter and a per-write strobe. Sits between the chip-level SPI pins and the PWM/control datapath, which consumes the flattened register bus.

## Interface
- `NUM_REGS`, default 8: number of registers, 1..128.
- `DATA_W`, default 8: register width in bits, 8..32.
- `RESET_VAL`, default 0: reset value loaded into every register.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `sclk` input 1: SPI clock, asynchronous to `clk`, idles low.
- `copi` input 1: controller-out data, asynchronous.
- `ncs` input 1: chip select, active low, asynchronous.
- `cipo` output 1: controller-in data.
- `cipo_oe` output 1: output enable for the `cipo` pad.
- `regs` output NUM_REGS*DATA_W: flattened register bank; register i occupies bits [i*DATA_W +: DATA_W].
- `wr_strobe` output 1: one-cycle pulse on each committed write.
- `wr_addr` output 7: address of the last committed write.
- `err_count` output 8: count of rejected frames, saturating.

## Operation
- Synchroniser: `sclk` uses 3 flops; `copi` and `ncs` use 2 flops each. SCLK rising and falling edges and NCS falling and rising edges are detected on the synchronised signals. All logic runs on `clk`.
- Frame layout, MSB first: bit 0 is R/W (1 = write), bits 1-7 are the address (MSB first), followed by DATA_W data bits (MSB first). The frame length is L = 8 + DATA_W.
- FSM states:
  - IDLE: on NCS fall, go to CMD; clear the bit counter and shift register.
  - CMD: shift `copi` in on each SCLK rise. After 8 bits, latch R/W and the address. Go to DATA.
  - DATA: shift data bits in on each SCLK rise.
  - COMMIT: entered on NCS rise from CMD or DATA. Always returns to IDLE on the next cycle.
- Bit counter: 6 bits wide, saturates at 63.
- Write commit (in COMMIT): requires R/W = 1, count == L exactly, and address < NUM_REGS. Then the addressed register gets the shifted data, `wr_addr` gets the address, and `wr_strobe` is high for one cycle.
- Rejected frames: a write with count != L, or a write with address >= NUM_REGS, increments `err_count` and leaves `regs` unchanged. A read with count != L also counts as an error. Reads never modify `regs`.
- `err_count` saturates at 255.
- NCS rise while in IDLE (glitch) is ignored.
- SCLK edges while `ncs` is high are ignored.
- Reset (asynchronous, including mid-frame): FSM goes to IDLE; counters, `wr_strobe`, `wr_addr`, `err_count`, `cipo` and `cipo_oe` go to 0. Every register goes to RESET_VAL. Any in-flight frame is discarded without error.

## Timing
- SCLK frequency must be at most f_clk/10.
- Edge detection lags the pin by 2-3 `clk` cycles.
- COMMIT occurs on the cycle after the synchronised NCS rise is detected. `regs` and `wr_addr` update, and `wr_strobe` pulses, on the following clock edge.
- Worst-case latency from the `ncs` pin rising to `regs` valid is 5 `clk` cycles.
- `wr_strobe` is never high for two consecutive cycles.
- Back-to-back frames need NCS high for at least 4 `clk` cycles.
- Read data: when the address is latched (8th SCLK rise), a shadow register loads regs[addr], or 0 if the address is out of range. On each SCLK fall in DATA, the shadow's MSB is driven on `cipo` and the shadow shifts left. This gives the controller its first data bit on the 9th SCLK rise.

## Configuration
- `SPI_READBACK_EN`
  - Defined: read path compiled in (shadow register and `cipo` shifter). `cipo_oe` equals the synchronised, inverted `ncs`.
  - Undefined: `cipo` and `cipo_oe` are tied to 0, no shadow logic exists, and read frames of any length are silently ignored (no `err_count` increment).

## Test plan
- Reset: assert `rst_n` low mid-frame -> `regs` all RESET_VAL, `err_count` = 0, `cipo_oe` = 0; the next valid frame succeeds.
- Write: 16-bit frame (write, address 3, data 0xA5) with defaults -> reg 3 = 0xA5, `wr_addr` = 3, one `wr_strobe` pulse, all other regs unchanged.
- Length errors: 15-bit and 17-bit write frames to address 1 -> reg 1 unchanged, `err_count` = 2, no `wr_strobe`.
- Address error: write to address 8 with NUM_REGS = 8 -> no write, `err_count` increments. Then 256 bad frames -> `err_count` = 255.
- Readback (`SPI_READBACK_EN` defined): write 0x3C to address 5, then read address 5 -> `cipo` bits on SCLK rises 9-16 are 0,0,1,1,1,1,0,0. A read of address 9 returns 0x00.
- Parametrised width: DATA_W = 16, NUM_REGS = 4; write 0xBEEF to address 2 -> `regs`[47:32] = 0xBEEF. A 16-bit frame to the same address is rejected.
